// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Note-event scheduler for a bank of NUM_VOICES envelope
//                generators. Accepts note-on/note-off events over a
//                valid/ready handshake, assigns note-ons to voices, drives
//                each voice's gate and key, tracks release completion via
//                voice_done, and steals a voice (with a forced gate-low gap)
//                when every voice is sounding.
//                Optional build macro STEAL_OLDEST_EN: the steal victim is
//                the voice with the largest 16-bit saturating age counter;
//                otherwise a round-robin pointer selects the victim.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int NUM_VOICES    = 4,
    parameter int KEY_W         = 7,
    parameter int RETRIG_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ev_valid,
    output logic                            ev_ready,
    input  logic                            ev_on,
    input  logic [KEY_W-1:0]                ev_key,
    input  logic [NUM_VOICES-1:0]           voice_done,
    output logic [NUM_VOICES-1:0]           gate,
    output logic [NUM_VOICES*KEY_W-1:0]     voice_key,
    output logic [$clog2(NUM_VOICES+1)-1:0] active_count,
    output logic                            steal_pulse
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    // Gap counter is loaded with RETRIG_CYCLES-1 and counts down to zero.
    localparam int GAP_W = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RETRIG_CYCLES - 1);

    typedef enum logic [1:0] {
        V_IDLE      = 2'd0,
        V_ACTIVE    = 2'd1,
        V_RELEASING = 2'd2,
        V_GAP       = 2'd3
    } voice_state_t;

    typedef enum logic [1:0] {
        C_INIT  = 2'd0,
        C_READY = 2'd1,
        C_BUSY  = 2'd2
    } ctrl_state_t;

    voice_state_t          vstate_q [NUM_VOICES];
    voice_state_t          vstate_d [NUM_VOICES];
    logic [KEY_W-1:0]      key_q    [NUM_VOICES];
    logic [KEY_W-1:0]      key_d    [NUM_VOICES];
    ctrl_state_t           ctrl_q;
    ctrl_state_t           ctrl_d;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic [GAP_W-1:0]      gap_cnt_d;
    logic [NUM_VOICES-1:0] gate_q;
    logic [NUM_VOICES-1:0] gate_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  ready_q;
    logic                  ready_d;
    logic                  steal_q;
    logic                  steal_d;

`ifdef STEAL_OLDEST_EN
    localparam int AGE_W = 16;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
    logic [AGE_W-1:0]      age_q    [NUM_VOICES];
    logic [AGE_W-1:0]      age_d    [NUM_VOICES];
    logic [AGE_W-1:0]      w_best_age;
`else
    logic [IDX_W-1:0]      rr_q;
    logic [IDX_W-1:0]      rr_d;
`endif

    logic                  w_accept;
    logic                  w_hit_found;
    logic [IDX_W-1:0]      w_hit_idx;
    logic                  w_idle_found;
    logic [IDX_W-1:0]      w_idle_idx;
    logic                  w_rel_found;
    logic [IDX_W-1:0]      w_rel_idx;
    logic [IDX_W-1:0]      w_victim_idx;
    logic [NUM_VOICES-1:0] w_assigned;

    assign w_accept = ev_valid & ready_q;

    // Priority scans over the registered voice states: retrigger hit, free
    // voice, releasing voice, and the steal victim.
    always_comb begin
        w_hit_found  = 1'b0;
        w_hit_idx    = '0;
        w_idle_found = 1'b0;
        w_idle_idx   = '0;
        w_rel_found  = 1'b0;
        w_rel_idx    = '0;
        w_victim_idx = '0;
`ifdef STEAL_OLDEST_EN
        w_best_age   = age_q[0];
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!w_hit_found && vstate_q[i] == V_ACTIVE && key_q[i] == ev_key) begin
                w_hit_found = 1'b1;
                w_hit_idx   = i[IDX_W-1:0];
            end
            if (!w_idle_found && vstate_q[i] == V_IDLE) begin
                w_idle_found = 1'b1;
                w_idle_idx   = i[IDX_W-1:0];
            end
            if (!w_rel_found && vstate_q[i] == V_RELEASING) begin
                w_rel_found = 1'b1;
                w_rel_idx   = i[IDX_W-1:0];
            end
`ifdef STEAL_OLDEST_EN
            // Strict compare keeps the lowest index on equal ages.
            if (age_q[i] > w_best_age) begin
                w_best_age   = age_q[i];
                w_victim_idx = i[IDX_W-1:0];
            end
`endif
        end
`ifndef STEAL_OLDEST_EN
        w_victim_idx = rr_q;
`endif
    end

    // Next-state logic for voices, controller, gap timer and registered outputs.
    always_comb begin
        ctrl_d     = ctrl_q;
        gap_cnt_d  = gap_cnt_q;
        steal_d    = 1'b0;
        w_assigned = '0;
`ifndef STEAL_OLDEST_EN
        rr_d       = rr_q;
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            vstate_d[i] = vstate_q[i];
            key_d[i]    = key_q[i];
        end

        if (ctrl_q == C_INIT) begin
            ctrl_d = C_READY;
        end

        // Background progress: gap countdown and release completion.
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (vstate_q[i] == V_GAP) begin
                if (gap_cnt_q == '0) begin
                    vstate_d[i] = V_ACTIVE;
                    ctrl_d      = C_READY;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            if (vstate_q[i] == V_RELEASING && voice_done[i]) begin
                vstate_d[i] = V_IDLE;
            end
        end

        // Event handling; allocation overrides a simultaneous voice_done.
        if (w_accept) begin
            if (ev_on) begin
                if (w_hit_found) begin
                    vstate_d[w_hit_idx] = V_GAP;
                    gap_cnt_d           = GAP_LOAD;
                    ctrl_d              = C_BUSY;
                end else if (w_idle_found) begin
                    vstate_d[w_idle_idx]   = V_ACTIVE;
                    key_d[w_idle_idx]      = ev_key;
                    w_assigned[w_idle_idx] = 1'b1;
                end else if (w_rel_found) begin
                    // Gate is already low, so no gap is needed.
                    vstate_d[w_rel_idx]   = V_ACTIVE;
                    key_d[w_rel_idx]      = ev_key;
                    w_assigned[w_rel_idx] = 1'b1;
                end else begin
                    vstate_d[w_victim_idx]   = V_GAP;
                    key_d[w_victim_idx]      = ev_key;
                    w_assigned[w_victim_idx] = 1'b1;
                    gap_cnt_d                = GAP_LOAD;
                    ctrl_d                   = C_BUSY;
                    steal_d                  = 1'b1;
`ifndef STEAL_OLDEST_EN
                    rr_d = (w_victim_idx == IDX_W'(NUM_VOICES - 1)) ?
                           '0 : w_victim_idx + IDX_W'(1);
`endif
                end
            end else begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (key_q[i] == ev_key) begin
                        if (vstate_q[i] == V_ACTIVE) begin
                            vstate_d[i] = V_RELEASING;
                        end else if (vstate_q[i] == V_GAP) begin
                            vstate_d[i] = V_RELEASING;
                            ctrl_d      = C_READY;
                        end
                    end
                end
            end
        end

`ifdef STEAL_OLDEST_EN
        for (int i = 0; i < NUM_VOICES; i++) begin
            age_d[i] = age_q[i];
            if (w_assigned[i]) begin
                age_d[i] = '0;
            end else if (vstate_q[i] != V_IDLE && age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
`endif

        count_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            gate_d[i] = (vstate_d[i] == V_ACTIVE);
            if (vstate_d[i] != V_IDLE) begin
                count_d = count_d + CNT_W'(1);
            end
        end
        ready_d = (ctrl_d == C_READY);
    end

    // State and registered-output flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= C_INIT;
            gap_cnt_q <= '0;
            gate_q    <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            steal_q   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate_q[i] <= V_IDLE;
                key_q[i]    <= '0;
`ifdef STEAL_OLDEST_EN
                age_q[i]    <= '0;
`endif
            end
`ifndef STEAL_OLDEST_EN
            rr_q      <= '0;
`endif
        end else begin
            ctrl_q    <= ctrl_d;
            gap_cnt_q <= gap_cnt_d;
            gate_q    <= gate_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            steal_q   <= steal_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate_q[i] <= vstate_d[i];
                key_q[i]    <= key_d[i];
`ifdef STEAL_OLDEST_EN
                age_q[i]    <= age_d[i];
`endif
            end
`ifndef STEAL_OLDEST_EN
            rr_q      <= rr_d;
`endif
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_key_out
            assign voice_key[g*KEY_W +: KEY_W] = key_q[g];
        end
    endgenerate

    assign gate         = gate_q;
    assign active_count = count_q;
    assign ev_ready     = ready_q;
    assign steal_pulse  = steal_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_allocator
//  Description : Self-checking bench for voice_allocator: directed steps
//                followed by random events, compared every cycle against a
//                voice-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int KW = 7;
    localparam int RT = 2;

    logic           clk        = 1'b0;
    logic           reset      = 1'b0;
    logic           ev_valid   = 1'b0;
    logic           ev_on      = 1'b0;
    logic [KW-1:0]  ev_key     = '0;
    logic [NV-1:0]  voice_done = '0;
    logic           ev_ready;
    logic [NV-1:0]  gate;
    logic [NV*KW-1:0] voice_key;
    logic [2:0]     active_count;
    logic           steal_pulse;

    int n_vec = 0;
    int n_err = 0;

    voice_allocator #(
        .NUM_VOICES    (NV),
        .KEY_W         (KW),
        .RETRIG_CYCLES (RT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_key       (ev_key),
        .voice_done   (voice_done),
        .gate         (gate),
        .voice_key    (voice_key),
        .active_count (active_count),
        .steal_pulse  (steal_pulse)
    );

    always #5 clk = ~clk;

    // Model: per voice "sounding", "fading", low-gate cycles left before retrigger.
    bit m_snd  [NV];
    bit m_fad  [NV];
    int m_wait [NV];
    int m_key  [NV];
    int m_age  [NV];
    int m_rr;
    bit m_ready;
    bit m_steal;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_snd[i] = 0; m_fad[i] = 0; m_wait[i] = 0; m_key[i] = 0; m_age[i] = 0;
        end
        m_rr = 0; m_ready = 0; m_steal = 0;
    endtask

    task automatic model_step(input bit v, input bit on, input int k, input logic [NV-1:0] done);
        bit o_snd [NV];
        bit o_fad [NV];
        int o_wait[NV];
        int o_age [NV];
        bit o_idle[NV];
        bit took  [NV];
        int pick;
        o_snd = m_snd; o_fad = m_fad; o_wait = m_wait; o_age = m_age;
        for (int i = 0; i < NV; i++) begin
            o_idle[i] = !o_snd[i] && !o_fad[i] && (o_wait[i] == 0);
            took[i]   = 0;
        end
        m_steal = 0;
        for (int i = 0; i < NV; i++) begin
            if (o_wait[i] > 0) begin
                m_wait[i]--;
                if (m_wait[i] == 0) m_snd[i] = 1;
            end
            if (o_fad[i] && done[i]) m_fad[i] = 0;
        end
        if (v && m_ready) begin
            pick = -1;
            if (on) begin
                for (int i = 0; i < NV; i++)
                    if (pick < 0 && o_snd[i] && m_key[i] == k) pick = i;
                if (pick >= 0) begin
                    m_snd[pick] = 0; m_wait[pick] = RT;
                end else begin
                    for (int i = 0; i < NV; i++) if (pick < 0 && o_idle[i]) pick = i;
                    for (int i = 0; i < NV; i++) if (pick < 0 && o_fad[i]) pick = i;
                    if (pick >= 0) begin
                        m_snd[pick] = 1; m_fad[pick] = 0; m_key[pick] = k; took[pick] = 1;
                    end else begin
`ifdef STEAL_OLDEST_EN
                        pick = 0;
                        for (int i = 1; i < NV; i++) if (o_age[i] > o_age[pick]) pick = i;
`else
                        pick = m_rr;
                        m_rr = (pick + 1) % NV;
`endif
                        m_snd[pick] = 0; m_wait[pick] = RT; m_key[pick] = k;
                        took[pick] = 1; m_steal = 1;
                    end
                end
            end else begin
                for (int i = 0; i < NV; i++) begin
                    if (m_key[i] == k) begin
                        if (o_snd[i]) begin
                            m_snd[i] = 0; m_fad[i] = 1;
                        end else if (o_wait[i] > 0) begin
                            m_snd[i] = 0; m_wait[i] = 0; m_fad[i] = 1;
                        end
                    end
                end
            end
        end
        for (int i = 0; i < NV; i++) begin
            if (took[i]) m_age[i] = 0;
            else if (!o_idle[i] && m_age[i] < 65535) m_age[i]++;
        end
        m_ready = 1;
        for (int i = 0; i < NV; i++) if (m_wait[i] > 0) m_ready = 0;
    endtask

    task automatic check_all(input string tag);
        logic [NV-1:0]    eg;
        logic [NV*KW-1:0] ek;
        int               ec;
        ec = 0;
        for (int i = 0; i < NV; i++) begin
            eg[i] = m_snd[i];
            ek[i*KW +: KW] = KW'(m_key[i]);
            if (m_snd[i] || m_fad[i] || m_wait[i] > 0) ec++;
        end
        chk({tag, "/ready"}, 32'(ev_ready), 32'(m_ready));
        chk({tag, "/gate"},  32'(gate), 32'(eg));
        chk({tag, "/key"},   32'(voice_key), 32'(ek));
        chk({tag, "/count"}, 32'(active_count), 32'(ec));
        chk({tag, "/steal"}, 32'(steal_pulse), 32'(m_steal));
    endtask

    task automatic cyc(input bit v, input bit on, input int k, input logic [NV-1:0] done,
                       input string tag);
        ev_valid = v; ev_on = on; ev_key = KW'(k); voice_done = done;
        model_step(v, on, k, done);
        @(posedge clk);
        #1;
        ev_valid = 1'b0; voice_done = '0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gate",  32'(gate), 0);
        chk("rst_ready", 32'(ev_ready), 0);
        chk("rst_count", 32'(active_count), 0);
        chk("rst_key",   32'(voice_key), 0);
        chk("rst_steal", 32'(steal_pulse), 0);
        #2 reset = 1'b1;

        cyc(0, 0, 0, 4'b0000, "idle0");
        chk("t0_ready", 32'(ev_ready), 1);

        // Fill all four voices.
        cyc(1, 1, 60, 4'b0000, "on60");  chk("t1_g60", 32'(gate), 4'b0001);
        cyc(1, 1, 62, 4'b0000, "on62");  chk("t1_g62", 32'(gate), 4'b0011);
        cyc(1, 1, 64, 4'b0000, "on64");  chk("t1_g64", 32'(gate), 4'b0111);
        cyc(1, 1, 66, 4'b0000, "on66");  chk("t1_g66", 32'(gate), 4'b1111);
        chk("t1_count", 32'(active_count), 4);

        // Steal with gap; an event offered during the gap is not taken.
        cyc(1, 1, 70, 4'b0000, "steal70");
        chk("t2_steal", 32'(steal_pulse), 1);
        chk("t2_gate",  32'(gate), 4'b1110);
        chk("t2_ready", 32'(ev_ready), 0);
        cyc(1, 1, 75, 4'b0000, "gap1");
        chk("t2_gap1",  32'(gate), 4'b1110);
        cyc(0, 0, 0, 4'b0000, "gap2");
        chk("t2_regate", 32'(gate), 4'b1111);
        chk("t2_key0",   32'(voice_key[KW-1:0]), 70);
        cyc(1, 1, 74, 4'b0000, "steal74");
        chk("t2b_gate", 32'(gate), 4'b1101);
        cyc(0, 0, 0, 4'b0000, "gap3");
        cyc(0, 0, 0, 4'b0000, "gap4");
        chk("t2b_key1", 32'(voice_key[2*KW-1:KW]), 74);

        // Release, reuse of a releasing voice, retrigger, done, stray note-off.
        cyc(1, 0, 74, 4'b0000, "off74");   chk("t3_gate", 32'(gate), 4'b1101);
        cyc(1, 1, 62, 4'b0000, "on62rel"); chk("t4_gate", 32'(gate), 4'b1111);
        chk("t4_key1", 32'(voice_key[2*KW-1:KW]), 62);
        cyc(1, 1, 62, 4'b0000, "retrig62");
        chk("t4_rt_gate",  32'(gate), 4'b1101);
        chk("t4_rt_steal", 32'(steal_pulse), 0);
        cyc(0, 0, 0, 4'b0000, "rtgap1");   chk("t4_rt_low", 32'(gate), 4'b1101);
        cyc(0, 0, 0, 4'b0000, "rtgap2");   chk("t4_rt_high", 32'(gate), 4'b1111);
        cyc(1, 0, 62, 4'b0000, "off62");   chk("t3_cnt4", 32'(active_count), 4);
        cyc(0, 0, 0, 4'b0010, "done1");    chk("t3_cnt3", 32'(active_count), 3);
        cyc(1, 0, 99, 4'b0000, "off99");   chk("t3_g99", 32'(gate), 4'b1101);

        // Allocation wins over a simultaneous voice_done.
        cyc(1, 1, 80, 4'b0000, "on80");
        cyc(1, 0, 64, 4'b0000, "off64");   chk("t5_rel", 32'(gate), 4'b1011);
        cyc(1, 1, 72, 4'b0100, "on72done");
        chk("t5_gate", 32'(gate), 4'b1111);
        chk("t5_key2", 32'(voice_key[3*KW-1:2*KW]), 72);

        // Asynchronous reset in the middle of a gap.
        cyc(1, 1, 90, 4'b0000, "steal90");
        chk("t6_steal", 32'(steal_pulse), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_gate",  32'(gate), 0);
        chk("t6_ready", 32'(ev_ready), 0);
        chk("t6_count", 32'(active_count), 0);
        model_reset();
        #2 reset = 1'b1;
        cyc(0, 0, 0, 4'b0000, "post_rst");
        chk("t6_ready1", 32'(ev_ready), 1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [NV-1:0] d;
            d = NV'($urandom_range(0, 15) & $urandom_range(0, 15));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6,
                60 + int'($urandom_range(0, 7)), d, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Note-event scheduler in front of a bank of NUM_VOICES envelope generators. It accepts note-on/note-off events over a valid/ready handshake and assigns each note-on to a voice. It drives each voice's gate (the envelope's note_on) and key, and tracks each voice's lifecycle using the envelope's end-of-release flag. When all voices are busy, it steals one with a short forced-release gap before retriggering it.

Parameters:
NUM_VOICES, 4, number of envelope voices managed (2..16)
KEY_W, 7, width of the note/key code
RETRIG_CYCLES, 2, clk cycles a stolen or retriggered voice's gate is held low before re-assertion (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
ev_valid  input  1  event present
ev_ready  output  1  allocator can accept an event this cycle
ev_on  input  1  1 = note-on, 0 = note-off
ev_key  input  KEY_W  key code of the event
voice_done  input  NUM_VOICES  per-voice end-of-release flag from the envelopes (level)
gate  output  NUM_VOICES  per-voice note_on to the envelopes
voice_key  output  NUM_VOICES*KEY_W  key held by each voice; voice i occupies bits [i*KEY_W +: KEY_W]
active_count  output  $clog2(NUM_VOICES+1)  number of voices not IDLE
steal_pulse  output  1  one-cycle pulse when a voice is stolen

Behaviour:
- Reset (reset=0, async): every voice IDLE, gate=0, voice_key=0, active_count=0, steal_pulse=0, ev_ready=0. ev_ready rises on the first clk edge after reset deasserts.
- Per-voice states: IDLE, ACTIVE (gate=1), RELEASING (gate=0, waiting for voice_done), GAP (gate=0, counting RETRIG_CYCLES).
- Controller FSM: READY (ev_ready=1) and BUSY (ev_ready=0, a voice is in GAP). An event is accepted on the edge where ev_valid & ev_ready.
- Note-on, key already in an ACTIVE voice:
  - That voice enters GAP and the controller enters BUSY.
  - This is a retrigger; steal_pulse stays 0.
- Note-on, otherwise:
  - If any voice is IDLE, the lowest-index IDLE voice takes the key and goes ACTIVE. gate=1 on the cycle after acceptance, latency 1.
  - Else, if any voice is RELEASING, the lowest-index RELEASING voice takes the key and goes ACTIVE, latency 1. No gap is needed because its gate is already low.
  - Else (all voices ACTIVE), the victim is chosen by the steal policy. The victim takes the new key, goes to GAP, and steal_pulse=1 for one cycle. The controller enters BUSY.
- GAP: gate=0 for exactly RETRIG_CYCLES cycles, then the voice goes ACTIVE with gate=1. The controller returns to READY in that same cycle. Latency from acceptance to gate=1 is RETRIG_CYCLES+1.
- Note-off: every ACTIVE voice whose key matches goes RELEASING, and gate falls on the next cycle.
  - A note-off with no matching voice is accepted and ignored.
  - A voice in GAP with a matching key is aborted to RELEASING, and the controller returns to READY.
- voice_done=1 on a RELEASING voice moves it to IDLE on the next edge. voice_done is ignored in ACTIVE and GAP.
- Simultaneous events: allocation uses the registered voice states. A voice whose voice_done arrives in the same cycle as a note-on counts as RELEASING for that note-on; allocation wins and the voice goes ACTIVE.
- active_count is registered and counts ACTIVE + RELEASING + GAP voices.
- voice_key holds its last value while a voice is IDLE.

Optional Feature:
Macro STEAL_OLDEST_EN.
- Defined: each voice has an age counter, width 16, saturating. The counter clears when the voice is assigned a key and increments every clk cycle while the voice is not IDLE. The victim is the voice with the largest age; ties go to the lowest index.
- Not defined: the victim comes from a round-robin pointer. It starts at 0 after reset, and after each steal it advances to victim+1, wrapping modulo NUM_VOICES.

Test Plan:
1. Reset release, then note-on keys 60,62,64,66 one per cycle -> voices 0..3 gate=1, each one cycle after its acceptance; active_count=4; steal_pulse never 1.
2. With all 4 voices ACTIVE (keys 60..66), note-on key 70 -> steal_pulse=1.
   - Without the macro, voice 0 gate=0 for 2 cycles, then gate=1 with voice_key[0]=70; ev_ready=0 during the gap. A second steal takes voice 1.
   - With STEAL_OLDEST_EN, voice 0 is also the victim because it was assigned first.
3. Note-off key 62 -> voice 1 gate=0 next cycle. voice_done[1]=1 -> active_count drops from 4 to 3 on the next edge. Note-off key 99 -> no gate change.
4. Note-on key 62 while voice 1 is RELEASING and no voice is IDLE -> voice 1 gate=1 next cycle with no gap. Repeated note-on key 62 while voice 1 is ACTIVE -> gate low for 2 cycles, then high; steal_pulse stays 0.
5. Drive voice_done[2]=1 in the same cycle a note-on key 72 is accepted, with voice 2 RELEASING and no voice IDLE -> voice 2 goes ACTIVE with key 72, not IDLE.
6. Pull reset=0 mid-GAP -> all gates 0 and ev_ready=0 immediately; after release, ev_ready=1 and active_count=0.
